// File: rtl/bus_slave_regs_pkg.sv
// Shared bus constants, slave register indices and slave FSM encodings
// for the four-word memory-mapped register slave.
package bus_slave_regs_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    localparam logic [1:0] CTRL_IDX    = 2'd0;
    localparam logic [1:0] DATA_IDX    = 2'd1;
    localparam logic [1:0] SCRATCH_IDX = 2'd2;
    localparam logic [1:0] COUNT_IDX   = 2'd3;

    typedef enum logic [1:0] {
        BUS_SLAVE_IDLE = 2'd0,
        BUS_SLAVE_WAIT = 2'd1,
        BUS_SLAVE_RESP = 2'd2
    } bus_slave_state_e;

endpackage

// File: rtl/bus_slave_regs.sv
// Memory-mapped bus slave: four-word register bank with programmable wait
// states, an active-low one-cycle ready pulse and a read-only access counter.
module bus_slave_regs
    import bus_slave_regs_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs_,
    input  logic                  as_,
    input  logic                  rw,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rdy_,
    output logic [DATA_WIDTH-1:0] ctrl
);

    localparam logic [DATA_WIDTH-1:0] ZERO_W   = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ONE_W    = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam bit                    HAS_WAIT = (WAIT_CYCLES > 32'sd0);
    // Unused when HAS_WAIT is clear; the truncated value is never loaded then.
    localparam logic [3:0]            WAIT_LOAD = 4'(WAIT_CYCLES - 32'sd1);

    bus_slave_state_e        state_q, state_d;
    logic [3:0]              wait_cnt_q, wait_cnt_d;
    logic [1:0]              addr_q, addr_d;
    logic                    rw_q, rw_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   scratch_q, scratch_d;
    logic [DATA_WIDTH-1:0]   count_q, count_d;
    logic                    rdy_q, rdy_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;

    logic                    req_s;
    logic                    enter_resp_s;
    logic [1:0]              acc_addr_s;
    logic                    acc_rw_s;
    logic [DATA_WIDTH-1:0]   acc_wdata_s;
    logic [DATA_WIDTH-1:0]   rd_mux_s;

    assign req_s = (cs_ == ENABLE_) && (as_ == ENABLE_);

    // Next-state, request capture and COUNT increment.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        addr_d       = addr_q;
        rw_d         = rw_q;
        wdata_d      = wdata_q;
        count_d      = count_q;
        enter_resp_s = 1'b0;
        acc_addr_s   = addr_q;
        acc_rw_s     = rw_q;
        acc_wdata_s  = wdata_q;
        case (state_q)
            BUS_SLAVE_IDLE: begin
                if (req_s) begin
                    addr_d  = addr;
                    rw_d    = rw;
                    wdata_d = wr_data;
                    if (HAS_WAIT) begin
                        state_d    = BUS_SLAVE_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        // Zero-wait: the access completes from the live bus inputs.
                        state_d      = BUS_SLAVE_RESP;
                        enter_resp_s = 1'b1;
                        acc_addr_s   = addr;
                        acc_rw_s     = rw;
                        acc_wdata_s  = wr_data;
                    end
                end else begin
                    state_d = BUS_SLAVE_IDLE;
                end
            end
            BUS_SLAVE_WAIT: begin
                if (!req_s) begin
                    state_d = BUS_SLAVE_IDLE;
                end else if (wait_cnt_q == 4'd0) begin
                    state_d      = BUS_SLAVE_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            BUS_SLAVE_RESP: begin
                state_d = BUS_SLAVE_IDLE;
                count_d = count_q + ONE_W;
            end
            default: begin
                state_d = BUS_SLAVE_IDLE;
            end
        endcase
    end

    // Read multiplexer over the register bank.
    always_comb begin
        rd_mux_s = ZERO_W;
        case (acc_addr_s)
            CTRL_IDX:    rd_mux_s = ctrl_q;
            DATA_IDX:    rd_mux_s = data_q;
            SCRATCH_IDX: rd_mux_s = scratch_q;
            COUNT_IDX:   rd_mux_s = count_q;
            default:     rd_mux_s = ZERO_W;
        endcase
    end

    // Response and register writes, both taking effect on the RESP-entry edge.
    always_comb begin
        rdy_d     = DISABLE_;
        rd_data_d = ZERO_W;
        ctrl_d    = ctrl_q;
        data_d    = data_q;
        scratch_d = scratch_q;
        if (enter_resp_s) begin
            rdy_d = ENABLE_;
            if (acc_rw_s == READ) begin
                rd_data_d = rd_mux_s;
            end else begin
                case (acc_addr_s)
                    CTRL_IDX:    ctrl_d    = acc_wdata_s;
                    DATA_IDX:    data_d    = acc_wdata_s;
                    SCRATCH_IDX: scratch_d = acc_wdata_s;
                    default:     ctrl_d    = ctrl_q;
                endcase
            end
        end else begin
            rdy_d = DISABLE_;
        end
    end

    // State and register bank flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= BUS_SLAVE_IDLE;
            wait_cnt_q <= 4'd0;
            addr_q     <= 2'd0;
            rw_q       <= READ;
            wdata_q    <= ZERO_W;
            ctrl_q     <= ZERO_W;
            data_q     <= ZERO_W;
            scratch_q  <= ZERO_W;
            count_q    <= ZERO_W;
            rdy_q      <= DISABLE_;
            rd_data_q  <= ZERO_W;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            wdata_q    <= wdata_d;
            ctrl_q     <= ctrl_d;
            data_q     <= data_d;
            scratch_q  <= scratch_d;
            count_q    <= count_d;
            rdy_q      <= rdy_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rdy_    = rdy_q;
    assign rd_data = rd_data_q;
    assign ctrl    = ctrl_q;

endmodule
